// File: rtl/fix_pkg.sv
// Shared FIX types: byte type, delimiters, TX beat payload and TX FIFO read-state encoding.
package fix_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    localparam byte_t FIX_EOM = 8'h3b;
    localparam byte_t FIX_SOH = 8'h01;

    // One byte presented to the TOE, with its end-of-message tag.
    typedef struct packed {
        byte_t data;
        logic  last;
    } tx_beat_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CUT  = 2'd2
    } txf_state_e;

endpackage

// File: rtl/fix_tx_fifo_mem.sv
// DEPTH x 8 simple dual-port RAM with a registered, write-through read port;
// the read register also tags bytes equal to TAG_BYTE.
module fix_tx_fifo_mem
    import fix_pkg::*;
#(
    parameter int unsigned DEPTH    = 64,
    parameter byte_t       TAG_BYTE = FIX_EOM,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  byte_t         wr_data,
    input  logic [AW-1:0] rd_addr,
    output tx_beat_t      rd_beat
);

    byte_t mem [DEPTH];
    byte_t rd_byte;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A byte written to the slot being read this cycle is forwarded, so a
    // just-written head byte is visible on the next cycle.
    always_comb begin
        rd_byte = mem[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_byte = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_beat <= '0;
        end else begin
            rd_beat.data <= rd_byte;
            rd_beat.last <= (rd_byte == TAG_BYTE);
        end
    end

endmodule

// File: rtl/fix_tx_fifo.sv
// Store-and-forward byte FIFO between fix_engine and the TOE: releases only complete
// messages, with a cut-through escape when a single message fills the buffer.
module fix_tx_fifo
    import fix_pkg::*;
#(
    parameter int unsigned  DEPTH       = 64,
    parameter byte_t        EOM_BYTE    = FIX_EOM,
    parameter int unsigned  FULL_MARGIN = 2,
    localparam int unsigned AW          = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_write_i,
    input  byte_t       message_i,
    output logic        fifo_full_o,
    output logic        tx_valid_o,
    output byte_t       tx_data_o,
    output logic        tx_last_o,
    input  logic        tx_ready_i,
    output logic [AW:0] msg_count_o,
    output logic        overflow_o
);

    localparam int unsigned PW       = AW + 1;
    localparam logic [AW:0] FULL_LVL = PW'(DEPTH - FULL_MARGIN);

    txf_state_e  state;
    txf_state_e  state_next;
    logic        eom_pending;
    logic        eom_pending_next;
    logic        valid_next;

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_ptr_next;
    logic [AW:0] rd_ptr_next;
    logic [AW:0] occ;
    logic [AW:0] occ_next;
    logic [AW:0] msg_count_next;

    logic        full;
    logic        wr_acc;
    logic        wr_eom;
    logic        hs;
    logic        rd_eom;
    logic        msg_inc;
    logic        msg_dec;
    tx_beat_t    head;

    assign occ    = wr_ptr - rd_ptr;
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_acc = fifo_write_i && !full;
    assign wr_eom = wr_acc && (message_i == EOM_BYTE);
    assign hs     = tx_valid_o && tx_ready_i;
    assign rd_eom = hs && head.last;

    // The first EOM written during cut-through closes the message already
    // streaming out, so it is never counted as a buffered complete message.
    assign msg_inc = wr_eom && !((state == CUT) && !eom_pending);
    assign msg_dec = rd_eom && (state == SEND);

    assign wr_ptr_next    = wr_ptr + PW'(wr_acc);
    assign rd_ptr_next    = rd_ptr + PW'(hs);
    assign occ_next       = occ + PW'(wr_acc) - PW'(hs);
    assign msg_count_next = msg_count_o + PW'(msg_inc) - PW'(msg_dec);

    fix_tx_fifo_mem #(
        .DEPTH    (DEPTH),
        .TAG_BYTE (EOM_BYTE)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (message_i),
        .rd_addr (rd_ptr_next[AW-1:0]),
        .rd_beat (head)
    );

    assign tx_data_o = head.data;
    assign tx_last_o = head.last;

    // Read-side state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            eom_pending <= 1'b0;
        end else begin
            state       <= state_next;
            eom_pending <= eom_pending_next;
        end
    end

    // Read-side next state and next tx_valid
    always_comb begin
        state_next       = state;
        eom_pending_next = eom_pending;
        valid_next       = 1'b0;

        case (state)
            IDLE: begin
                if (msg_count_o != '0) begin
                    state_next = SEND;
                end else if (full) begin
                    state_next = CUT;
                end
            end
            SEND: begin
                if (rd_eom && (msg_count_next == '0)) begin
                    state_next = IDLE;
                end
            end
            CUT: begin
                if (rd_eom) begin
                    state_next       = IDLE;
                    eom_pending_next = 1'b0;
                end else if (wr_eom) begin
                    eom_pending_next = 1'b1;
                end
            end
            default: begin
                state_next       = IDLE;
                eom_pending_next = 1'b0;
            end
        endcase

        case (state_next)
            SEND:    valid_next = 1'b1;
            CUT:     valid_next = (occ_next != '0);
            default: valid_next = 1'b0;
        endcase
    end

    // Pointers, counters and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            msg_count_o <= '0;
            fifo_full_o <= 1'b0;
            overflow_o  <= 1'b0;
            tx_valid_o  <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_next;
            rd_ptr      <= rd_ptr_next;
            msg_count_o <= msg_count_next;
            fifo_full_o <= (occ_next >= FULL_LVL);
            overflow_o  <= fifo_write_i && full;
            tx_valid_o  <= valid_next;
        end
    end

endmodule
